// File: rtl/coreriscv_axi4_clint_pkg.sv
// coreriscv_axi4_clint_pkg
// Shared definitions for the core-local interruptor: register map
// constants, the response record carried by the single response stage,
// the decoded register-select enum and a byte-mask expansion helper.
package coreriscv_axi4_clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_ADDR    = 16'hBFF8;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  id;
    logic        error;
  } resp_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_MSIP,
    SEL_MTIMECMP,
    SEL_MTIME
  } sel_e;

  // Turns an 8-bit byte-enable into a 64-bit bit mask.
  function automatic logic [63:0] expand_mask(input logic [7:0] mask);
    logic [63:0] bits;
    bits = '0;
    for (int i = 0; i < 8; i++) begin
      bits[i*8 +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/coreriscv_axi4_clint_rtcdiv.sv
// coreriscv_axi4_clint_rtcdiv
// Tick source for mtime. With RTC_DIV = 0 the external rtc_tick is passed
// straight through; with RTC_DIV >= 2 a prescaler counts 0..RTC_DIV-1 and
// ticks on the cycle it holds RTC_DIV-1.
// Ports:
//   clk      - clock
//   reset_n  - synchronous active-low reset
//   rtc_tick - external tick, each high cycle counts once
//   tick     - selected tick, one cycle wide
module coreriscv_axi4_clint_rtcdiv #(
  parameter int RTC_DIV = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rtc_tick,
  output logic tick
);

  // The counter is always built so the module elaborates identically for
  // both tick sources; with the external source it is simply unobserved.
  localparam int PERIOD = (RTC_DIV >= 2) ? RTC_DIV : 2;
  localparam logic [15:0] LAST = 16'(PERIOD - 1);

  logic [15:0] count_q;
  logic        wrap;

  assign wrap = (count_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (wrap) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 16'd1;
    end
  end

  assign tick = (RTC_DIV == 0) ? rtc_tick : wrap;

endmodule

// File: rtl/coreriscv_axi4_clint.sv
// coreriscv_axi4_clint
// Multi-hart core-local interruptor: shared mtime counter, per-hart
// mtimecmp and msip registers behind a valid/ready request/response port
// with a single response stage.
// Ports:
//   clk, reset_n                - clock, synchronous active-low reset
//   req_valid/req_ready         - request handshake
//   req_write/addr/data/mask/id - request payload (64-bit word access)
//   resp_valid/resp_ready       - response handshake
//   resp_data/resp_id/resp_error- response payload
//   rtc_tick                    - external tick (used when RTC_DIV = 0)
//   msip, mtip                  - per-hart software / timer interrupts
module coreriscv_axi4_clint
  import coreriscv_axi4_clint_pkg::*;
#(
  parameter int N_HARTS = 1,
  parameter int TIME_W  = 64,
  parameter int RTC_DIV = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [15:0]        req_addr,
  input  logic [63:0]        req_data,
  input  logic [7:0]         req_mask,
  input  logic [1:0]         req_id,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [63:0]        resp_data,
  output logic [1:0]         resp_id,
  output logic               resp_error,
  input  logic               rtc_tick,
  output logic [N_HARTS-1:0] msip,
  output logic [N_HARTS-1:0] mtip
);

  // Two harts share each msip word; an odd hart count leaves a phantom bit.
  localparam int MSIP_WORDS = (N_HARTS + 1) / 2;
  localparam int PAD_W      = 2 * MSIP_WORDS;

  logic [TIME_W-1:0]  mtime_q;
  logic [TIME_W-1:0]  mtime_inc;
  logic [TIME_W-1:0]  mtime_nxt;
  logic [TIME_W-1:0]  mtimecmp_q [N_HARTS];
  logic [N_HARTS-1:0] msip_q;
  logic [N_HARTS-1:0] mtip_q;
  logic [N_HARTS-1:0] cmp_ge;
  logic [PAD_W-1:0]   msip_pad;
  logic [PAD_W-1:0]   msip_nxt;

  resp_t       resp_q;
  logic        resp_valid_q;
  logic        tick;
  logic        accept;
  logic        wr_en;
  logic [12:0] word;
  logic [12:0] msip_off;
  logic [12:0] cmp_off;
  sel_e        sel;
  logic [63:0] wmask;
  logic [63:0] rdata;
  logic        unused_bits;

  coreriscv_axi4_clint_rtcdiv #(
    .RTC_DIV (RTC_DIV)
  ) u_rtcdiv (
    .clk      (clk),
    .reset_n  (reset_n),
    .rtc_tick (rtc_tick),
    .tick     (tick)
  );

  assign req_ready = !resp_valid_q || resp_ready;
  assign accept    = req_valid && req_ready;
  assign wr_en     = accept && req_write;
  assign wmask     = expand_mask(req_mask);
  assign msip_pad  = PAD_W'(msip_q);

  // Offsets are taken modulo 2^13, so addresses below a region's base wrap
  // to large values and fall outside the hart-count bound.
  always_comb begin
    word     = req_addr[15:3];
    msip_off = word - MSIP_BASE[15:3];
    cmp_off  = word - MTIMECMP_BASE[15:3];
    sel      = SEL_NONE;
    if (word == MTIME_ADDR[15:3]) begin
      sel = SEL_MTIME;
    end else if (cmp_off < 13'(N_HARTS)) begin
      sel = SEL_MTIMECMP;
    end else if (msip_off < 13'(MSIP_WORDS)) begin
      sel = SEL_MSIP;
    end
  end

  // Read data comes from the current register values, i.e. before this
  // cycle's tick or write lands.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MSIP: begin
        for (int k = 0; k < MSIP_WORDS; k++) begin
          if (msip_off == 13'(k)) begin
            rdata[0]  = msip_pad[2*k];
            rdata[32] = msip_pad[2*k+1];
          end
        end
      end
      SEL_MTIMECMP: begin
        for (int h = 0; h < N_HARTS; h++) begin
          if (cmp_off == 13'(h)) begin
            rdata = 64'(mtimecmp_q[h]);
          end
        end
      end
      SEL_MTIME: rdata = 64'(mtime_q);
      default:   rdata = '0;
    endcase
  end

  // Written bytes take the write data, unwritten bytes still take the
  // ticked value, so a write never swallows a concurrent tick.
  always_comb begin
    mtime_inc = tick ? (mtime_q + TIME_W'(1)) : mtime_q;
    mtime_nxt = mtime_inc;
    if (wr_en && (sel == SEL_MTIME)) begin
      mtime_nxt = TIME_W'((req_data & wmask) | (64'(mtime_inc) & ~wmask));
    end
  end

  always_comb begin
    msip_nxt = msip_pad;
    if (wr_en && (sel == SEL_MSIP)) begin
      for (int k = 0; k < MSIP_WORDS; k++) begin
        if (msip_off == 13'(k)) begin
          if (req_mask[0]) msip_nxt[2*k]   = req_data[0];
          if (req_mask[4]) msip_nxt[2*k+1] = req_data[32];
        end
      end
    end
  end

  for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
    assign cmp_ge[h] = (mtime_q >= mtimecmp_q[h]);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mtime_q <= '0;
      msip_q  <= '0;
      mtip_q  <= '0;
      for (int h = 0; h < N_HARTS; h++) begin
        mtimecmp_q[h] <= '1;
      end
    end else begin
      mtime_q <= mtime_nxt;
      msip_q  <= msip_nxt[N_HARTS-1:0];
      mtip_q  <= cmp_ge;
      for (int h = 0; h < N_HARTS; h++) begin
        if (wr_en && (sel == SEL_MTIMECMP) && (cmp_off == 13'(h))) begin
          mtimecmp_q[h] <= TIME_W'((req_data & wmask) | (64'(mtimecmp_q[h]) & ~wmask));
        end
      end
    end
  end

  // Single response stage; a pending response is dropped by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else if (accept) begin
      resp_valid_q <= 1'b1;
      resp_q.data  <= req_write ? 64'd0 : rdata;
      resp_q.id    <= req_id;
      resp_q.error <= (sel == SEL_NONE);
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_q.data;
  assign resp_id    = resp_q.id;
  assign resp_error = resp_q.error;
  assign msip       = msip_q;
  assign mtip       = mtip_q;

  assign unused_bits = ^{req_addr[2:0], msip_nxt};

endmodule
